mdu_sched: RTL and testbench

Sequencing controller for the multiply/divide resource in the Execute stage of the pipelined MIPS CPU. It accepts MDU operations from E, computes signed or unsigned products and quotients, and holds busy for a fixed latency. It owns the HI/LO registers and raises a D-stage hazard so the hazard unit stalls dependent MDU instructions. It also suppresses any E-stage MDU side effect when the exception/interrupt request is asserted.

---
 rtl/mdu_sched_pkg.sv | 26 ++
 rtl/mdu_sched_if.sv | 25 ++
 rtl/mdu_sched.sv | 137 +++++++++++++
 tb/tb_mdu_sched.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_sched_pkg.sv
// Shared MDU opcode constants, scheduler state encoding and opcode helpers.
// Imported by the E-stage control unit and by mdu_sched.
package mdu_sched_pkg;

    localparam logic [3:0] MDU_none  = 4'd0;
    localparam logic [3:0] MDU_mult  = 4'd1;
    localparam logic [3:0] MDU_multu = 4'd2;
    localparam logic [3:0] MDU_div   = 4'd3;
    localparam logic [3:0] MDU_divu  = 4'd4;
    localparam logic [3:0] MDU_mfhi  = 4'd5;
    localparam logic [3:0] MDU_mflo  = 4'd6;
    localparam logic [3:0] MDU_mthi  = 4'd7;
    localparam logic [3:0] MDU_mtlo  = 4'd8;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv
    } mdu_state_e;

    // True for the opcodes that occupy the multiplier/divider.
    function automatic logic is_muldiv(logic [3:0] op);
        return (op >= MDU_mult) && (op <= MDU_divu);
    endfunction

endpackage

// File: rtl/mdu_sched_if.sv
// E-stage <-> MDU scheduler signal bundle. The scheduler uses the slave view,
// the pipeline (or testbench) drives through the master view.
interface mdu_sched_if;

    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        req;
    logic        d_is_md;
    logic        start;
    logic        busy;
    logic        md_hazard;
    logic [31:0] out;

    modport master (
        output op, rs, rt, req, d_is_md,
        input  start, busy, md_hazard, out
    );

    modport slave (
        input  op, rs, rt, req, d_is_md,
        output start, busy, md_hazard, out
    );

endinterface

// File: rtl/mdu_sched.sv
// Multiply/divide sequencer: computes the result at start, holds it pending for a
// fixed latency, then commits it to HI/LO. Raises a D-stage hazard while occupied.
module mdu_sched
    import mdu_sched_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    mdu_sched_if.slave  mdu
);

    mdu_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_ok_q, pend_ok_d;

    logic        start;
    logic        busy;
    logic        md_hazard;
    logic [31:0] out;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] divisor;
    logic [31:0] quo_s, rem_s, quo_u, rem_u;

    // Operands widened so the 64-bit product is exact in both signednesses.
    assign prod_s  = {{32{mdu.rs[31]}}, mdu.rs} * {{32{mdu.rt[31]}}, mdu.rt};
    assign prod_u  = {32'd0, mdu.rs} * {32'd0, mdu.rt};
    // A zero divisor is replaced so the operators stay defined; the result is discarded.
    assign divisor = (mdu.rt == 32'd0) ? 32'd1 : mdu.rt;
    assign quo_s   = $signed(mdu.rs) / $signed(divisor);
    assign rem_s   = $signed(mdu.rs) % $signed(divisor);
    assign quo_u   = mdu.rs / divisor;
    assign rem_u   = mdu.rs % divisor;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_ok_q <= pend_ok_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_ok_d = pend_ok_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    pend_ok_d = 1'b1;
                    unique case (mdu.op)
                        MDU_mult: begin
                            {pend_hi_d, pend_lo_d} = prod_s;
                            cnt_d   = 4'(MULT_CYCLES);
                            state_d = StMul;
                        end
                        MDU_multu: begin
                            {pend_hi_d, pend_lo_d} = prod_u;
                            cnt_d   = 4'(MULT_CYCLES);
                            state_d = StMul;
                        end
                        MDU_div: begin
                            pend_hi_d = rem_s;
                            pend_lo_d = quo_s;
                            pend_ok_d = (mdu.rt != 32'd0);
                            cnt_d     = 4'(DIV_CYCLES);
                            state_d   = StDiv;
                        end
                        default: begin
                            pend_hi_d = rem_u;
                            pend_lo_d = quo_u;
                            pend_ok_d = (mdu.rt != 32'd0);
                            cnt_d     = 4'(DIV_CYCLES);
                            state_d   = StDiv;
                        end
                    endcase
                end else if (!mdu.req && !busy) begin
                    if (mdu.op == MDU_mthi) hi_d = mdu.rs;
                    if (mdu.op == MDU_mtlo) lo_d = mdu.rs;
                end
            end
            StMul, StDiv: begin
                // req is ignored here: the op already left E and must commit.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (pend_ok_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        busy      = (cnt_q != 4'd0);
        start     = is_muldiv(mdu.op) && !mdu.req && !busy;
        md_hazard = mdu.d_is_md && (start || busy);
        out       = 32'd0;
        if (mdu.op == MDU_mfhi) out = hi_q;
        if (mdu.op == MDU_mflo) out = lo_q;
    end

    assign mdu.start     = start;
    assign mdu.busy      = busy;
    assign mdu.md_hazard = md_hazard;
    assign mdu.out       = out;

endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched: latency, HI/LO results, req cancellation,
// hazard window, divide by zero and mid-operation reset.
module tb_mdu_sched;
    import mdu_sched_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    mdu_sched_if bus ();

    mdu_sched #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .mdu  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reads HI and LO through mfhi/mflo within the current cycle.
    task automatic chk_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        bus.op = MDU_mfhi;
        #1 chk32({tag, "_hi"}, bus.out, hi);
        bus.op = MDU_mflo;
        #1 chk32({tag, "_lo"}, bus.out, lo);
        bus.op = MDU_none;
    endtask

    // Issues one mult/div and checks start, the exact busy window and its end.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n);
        bus.op = op;
        bus.rs = a;
        bus.rt = b;
        #1 chk1({tag, "_start"}, bus.start, 1'b1);
        tick();
        bus.op = MDU_none;
        for (int i = 1; i <= n; i++) begin
            #1 chk1({tag, "_busy"}, bus.busy, 1'b1);
            tick();
        end
        #1 chk1({tag, "_done"}, bus.busy, 1'b0);
    endtask

    initial begin
        int hz;
        bus.op      = MDU_none;
        bus.rs      = 32'd0;
        bus.rt      = 32'd0;
        bus.req     = 1'b0;
        bus.d_is_md = 1'b0;
        reset       = 1'b0;
        tick();
        tick();
        #1 chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_start", bus.start, 1'b0);
        chk32("rst_out", bus.out, 32'd0);
        chk_hilo("rst", 32'd0, 32'd0);
        reset = 1'b1;
        tick();

        // mult -2 * 3; old LO must still read back during busy (no bypass)
        bus.op = MDU_mult;
        bus.rs = 32'hFFFF_FFFE;
        bus.rt = 32'd3;
        #1 chk1("mult_start", bus.start, 1'b1);
        tick();
        bus.op = MDU_mflo;
        #1 chk32("mult_nobypass", bus.out, 32'd0);
        bus.op = MDU_none;
        for (int i = 1; i <= 5; i++) begin
            #1 chk1("mult_busy", bus.busy, 1'b1);
            tick();
        end
        #1 chk1("mult_done", bus.busy, 1'b0);
        chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        tick();
        run_op("divu", MDU_divu, 32'd17, 32'd5, 10);
        chk_hilo("divu", 32'd2, 32'd3);
        tick();
        run_op("div", MDU_div, 32'hFFFF_FFF9, 32'd2, 10);
        chk_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // req cancels a mult and an mthi in E
        tick();
        bus.op  = MDU_mult;
        bus.rs  = 32'd5;
        bus.rt  = 32'd5;
        bus.req = 1'b1;
        #1 chk1("req_start", bus.start, 1'b0);
        tick();
        bus.op = MDU_mthi;
        bus.rs = 32'hAA;
        #1 chk1("req_busy", bus.busy, 1'b0);
        tick();
        bus.op  = MDU_none;
        bus.req = 1'b0;
        chk_hilo("req", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // multu with hazard window and req pulse during busy
        tick();
        bus.d_is_md = 1'b1;
        bus.op      = MDU_multu;
        bus.rs      = 32'hFFFF_FFFF;
        bus.rt      = 32'd2;
        hz          = 0;
        #1 if (bus.md_hazard) hz++;
        tick();
        bus.op = MDU_none;
        for (int c = 1; c <= 8; c++) begin
            bus.req = (c == 3);
            #1 if (bus.md_hazard) hz++;
            tick();
        end
        bus.req     = 1'b0;
        bus.d_is_md = 1'b0;
        chk32("hazard_cycles", 32'(hz), 32'd6);
        chk_hilo("multu", 32'd1, 32'hFFFF_FFFE);

        // mthi/mtlo, then divide by zero leaves them intact
        tick();
        bus.op = MDU_mthi;
        bus.rs = 32'h11;
        tick();
        bus.op = MDU_mfhi;
        #1 chk32("mthi_next", bus.out, 32'h11);
        bus.op = MDU_mtlo;
        bus.rs = 32'h22;
        tick();
        chk_hilo("mt", 32'h11, 32'h22);
        tick();
        run_op("div0", MDU_div, 32'd100, 32'd0, 10);
        chk_hilo("div0", 32'h11, 32'h22);

        // reset during busy cycle 2 of a div
        tick();
        bus.op = MDU_div;
        bus.rs = 32'd100;
        bus.rt = 32'd7;
        #1 chk1("rstmid_start", bus.start, 1'b1);
        tick();
        bus.op = MDU_none;
        tick();
        #1 chk1("rstmid_busy2", bus.busy, 1'b1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1 chk1("rstmid_busy", bus.busy, 1'b0);
        chk_hilo("rstmid", 32'd0, 32'd0);
        repeat (12) tick();
        #1 chk1("rstmid_late_busy", bus.busy, 1'b0);
        chk_hilo("rstmid_late", 32'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
